// File: rtl/ocd_frame_parser_if.sv
`default_nettype none
// ============================================================================
//  Module      : ocd_frame_parser_if
//  Description : Bundle of the byte stream, core access and response signals
//                used by ocd_frame_parser.
//                master : the frame parser (drives core strobes and tx)
//                slave  : the environment (UART RX/TX side and the core)
//  Revision    : 1.0  initial release
// ============================================================================
interface ocd_frame_parser_if #(
    parameter int MEM_ADDR_BITS = 16,
    parameter int REG_ADDR_BITS = 5
);
    logic                     rx_valid;
    logic [7:0]               rx_data;
    logic                     ocd_read_enable;
    logic                     ocd_write_enable;
    logic [MEM_ADDR_BITS-1:0] ocd_rw_addr;
    logic [31:0]              ocd_write_word;
    logic                     ocd_mem_enable_out;
    logic [31:0]              ocd_mem_word_out;
    logic                     ocd_reg_we;
    logic [REG_ADDR_BITS-1:0] ocd_reg_write_addr;
    logic [31:0]              ocd_reg_write_data;
    logic                     start;
    logic [31:0]              start_address;
    logic                     tx_valid;
    logic [7:0]               tx_byte;
    logic                     tx_ready;

    modport master (
        input  rx_valid, rx_data, ocd_mem_enable_out, ocd_mem_word_out, tx_ready,
        output ocd_read_enable, ocd_write_enable, ocd_rw_addr, ocd_write_word,
               ocd_reg_we, ocd_reg_write_addr, ocd_reg_write_data,
               start, start_address, tx_valid, tx_byte
    );

    modport slave (
        output rx_valid, rx_data, ocd_mem_enable_out, ocd_mem_word_out, tx_ready,
        input  ocd_read_enable, ocd_write_enable, ocd_rw_addr, ocd_write_word,
               ocd_reg_we, ocd_reg_write_addr, ocd_reg_write_data,
               start, start_address, tx_valid, tx_byte
    );
endinterface
`default_nettype wire

// File: rtl/ocd_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module      : ocd_frame_parser
//  Description : On-chip-debug command parser. Receives 11-byte frames
//                (5A, CMD, ADDR[31:0], DATA[31:0], CSUM) from a UART byte
//                stream, issues one memory/register/start action to the core
//                and returns a 1- or 5-byte response over a tx handshake.
//  Ports       : clk        - clock, rising edge
//                reset_n    - asynchronous active-low reset
//                sync_reset - synchronous active-high reset
//                bus        - rx byte strobe, core access strobes/data,
//                             read return, tx byte handshake
//  Revision    : 1.0  initial release
// ============================================================================
module ocd_frame_parser #(
    parameter int MEM_ADDR_BITS  = 16,
    parameter int REG_ADDR_BITS  = 5,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sync_reset,
    ocd_frame_parser_if.master bus
);
    localparam logic [2:0] c_S_HUNT    = 3'd0;
    localparam logic [2:0] c_S_CMD     = 3'd1;
    localparam logic [2:0] c_S_ADDR    = 3'd2;
    localparam logic [2:0] c_S_DATA    = 3'd3;
    localparam logic [2:0] c_S_CSUM    = 3'd4;
    localparam logic [2:0] c_S_EXEC    = 3'd5;
    localparam logic [2:0] c_S_WAIT_RD = 3'd6;
    localparam logic [2:0] c_S_RESP    = 3'd7;

    localparam logic [7:0] c_SYNC        = 8'h5A;
    localparam logic [7:0] c_CMD_WRITE   = 8'h01;
    localparam logic [7:0] c_CMD_READ    = 8'h02;
    localparam logic [7:0] c_CMD_REG     = 8'h03;
    localparam logic [7:0] c_CMD_START   = 8'h04;
    localparam logic [7:0] c_RSP_OK      = 8'hA5;
    localparam logic [7:0] c_RSP_TIMEOUT = 8'hEC;
    localparam logic [7:0] c_RSP_CSUM    = 8'hEE;
    localparam logic [7:0] c_RSP_BADCMD  = 8'hEF;

    localparam int c_TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]               r_state;
    logic [2:0]               w_next_state;
    logic [1:0]               r_byte_cnt;
    logic [c_TW-1:0]          r_timer;
    logic [7:0]               r_cmd;
    logic [7:0]               r_csum;
    logic [31:0]              r_addr;
    logic [31:0]              r_data;
    logic [39:0]              r_resp;        // queued response, MSB byte goes out first
    logic [2:0]               r_resp_left;   // bytes still to send
    logic [MEM_ADDR_BITS-1:0] r_rw_addr;
    logic [31:0]              r_write_word;
    logic [REG_ADDR_BITS-1:0] r_reg_addr;
    logic [31:0]              r_reg_data;
    logic [31:0]              r_start_addr;

    logic w_timeout;
    logic w_csum_ok;
    logic w_counting;
    logic w_write_en;
    logic w_read_en;
    logic w_reg_we;
    logic w_start;
    logic w_tx_valid;
    logic w_unused;

    assign w_timeout  = (r_timer == c_TO_LAST);
    assign w_csum_ok  = (bus.rx_data == r_csum);
    assign w_counting = (r_state == c_S_CMD)  || (r_state == c_S_ADDR) ||
                        (r_state == c_S_DATA) || (r_state == c_S_CSUM) ||
                        (r_state == c_S_WAIT_RD);
    // Top address byte is only ever shifted out, never used.
    assign w_unused   = ^r_addr[31:24];

    // ------------------------------------------------------------------ state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_S_HUNT;
        end else if (sync_reset) begin
            r_state <= c_S_HUNT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------- next state
    // A received byte always wins over a timeout expiring in the same cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_HUNT:    if (bus.rx_valid && bus.rx_data == c_SYNC) w_next_state = c_S_CMD;
            c_S_CMD:     if (bus.rx_valid)                         w_next_state = c_S_ADDR;
                         else if (w_timeout)                       w_next_state = c_S_HUNT;
            c_S_ADDR:    if (bus.rx_valid && r_byte_cnt == 2'd3)   w_next_state = c_S_DATA;
                         else if (!bus.rx_valid && w_timeout)      w_next_state = c_S_HUNT;
            c_S_DATA:    if (bus.rx_valid && r_byte_cnt == 2'd3)   w_next_state = c_S_CSUM;
                         else if (!bus.rx_valid && w_timeout)      w_next_state = c_S_HUNT;
            c_S_CSUM:    if (bus.rx_valid)                         w_next_state = w_csum_ok ? c_S_EXEC : c_S_RESP;
                         else if (w_timeout)                       w_next_state = c_S_HUNT;
            c_S_EXEC:    w_next_state = (r_cmd == c_CMD_READ) ? c_S_WAIT_RD : c_S_RESP;
            c_S_WAIT_RD: if (bus.ocd_mem_enable_out || w_timeout)  w_next_state = c_S_RESP;
            c_S_RESP:    if (bus.tx_ready && r_resp_left == 3'd1)  w_next_state = c_S_HUNT;
            default:     w_next_state = c_S_HUNT;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    // Core strobes exist only during the single EXEC cycle.
    always_comb begin
        w_write_en = 1'b0;
        w_read_en  = 1'b0;
        w_reg_we   = 1'b0;
        w_start    = 1'b0;
        if (r_state == c_S_EXEC) begin
            case (r_cmd)
                c_CMD_WRITE: w_write_en = 1'b1;
                c_CMD_READ:  w_read_en  = 1'b1;
                c_CMD_REG:   w_reg_we   = 1'b1;
                c_CMD_START: w_start    = 1'b1;
                default:     ;
            endcase
        end
        w_tx_valid = (r_state == c_S_RESP);
    end

    // --------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_byte_cnt   <= '0;
            r_timer      <= '0;
            r_cmd        <= '0;
            r_csum       <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_resp       <= '0;
            r_resp_left  <= '0;
            r_rw_addr    <= '0;
            r_write_word <= '0;
            r_reg_addr   <= '0;
            r_reg_data   <= '0;
            r_start_addr <= '0;
        end else if (sync_reset) begin
            r_byte_cnt   <= '0;
            r_timer      <= '0;
            r_csum       <= '0;
            r_resp       <= '0;
            r_resp_left  <= '0;
            r_rw_addr    <= '0;
            r_write_word <= '0;
            r_reg_addr   <= '0;
            r_reg_data   <= '0;
            r_start_addr <= '0;
        end else begin
            // Bytes dropped while waiting for read data do not restart the wait.
            if (!w_counting || (bus.rx_valid && r_state != c_S_WAIT_RD)) begin
                r_timer <= '0;
            end else if (!w_timeout) begin
                r_timer <= r_timer + 1'b1;
            end

            if (w_next_state != r_state) begin
                r_byte_cnt <= '0;
            end else if (bus.rx_valid && (r_state == c_S_ADDR || r_state == c_S_DATA)) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end

            case (r_state)
                c_S_HUNT: r_csum <= '0;
                c_S_CMD: if (bus.rx_valid) begin
                    r_cmd  <= bus.rx_data;
                    r_csum <= r_csum ^ bus.rx_data;
                end
                c_S_ADDR: if (bus.rx_valid) begin
                    r_addr <= {r_addr[23:0], bus.rx_data};
                    r_csum <= r_csum ^ bus.rx_data;
                end
                c_S_DATA: if (bus.rx_valid) begin
                    r_data <= {r_data[23:0], bus.rx_data};
                    r_csum <= r_csum ^ bus.rx_data;
                end
                c_S_CSUM: if (bus.rx_valid) begin
                    r_resp_left <= 3'd1;
                    if (!w_csum_ok) begin
                        r_resp <= {c_RSP_CSUM, 32'h0};
                    end else begin
                        // Outputs update on entry to EXEC and hold until the next one.
                        r_resp <= {c_RSP_OK, 32'h0};
                        case (r_cmd)
                            c_CMD_WRITE: begin
                                r_rw_addr    <= r_addr[MEM_ADDR_BITS+1:2];
                                r_write_word <= r_data;
                            end
                            c_CMD_READ:  r_rw_addr <= r_addr[MEM_ADDR_BITS+1:2];
                            c_CMD_REG: begin
                                r_reg_addr <= r_addr[REG_ADDR_BITS-1:0];
                                r_reg_data <= r_data;
                            end
                            c_CMD_START: r_start_addr <= r_data;
                            default:     r_resp <= {c_RSP_BADCMD, 32'h0};
                        endcase
                    end
                end
                c_S_WAIT_RD: begin
                    if (bus.ocd_mem_enable_out) begin
                        r_resp      <= {c_RSP_OK, bus.ocd_mem_word_out};
                        r_resp_left <= 3'd5;
                    end else if (w_timeout) begin
                        r_resp      <= {c_RSP_TIMEOUT, 32'h0};
                        r_resp_left <= 3'd1;
                    end
                end
                c_S_RESP: if (bus.tx_ready) begin
                    r_resp      <= {r_resp[31:0], 8'h00};
                    r_resp_left <= r_resp_left - 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ocd_write_enable   = w_write_en;
    assign bus.ocd_read_enable    = w_read_en;
    assign bus.ocd_reg_we         = w_reg_we;
    assign bus.start              = w_start;
    assign bus.ocd_rw_addr        = r_rw_addr;
    assign bus.ocd_write_word     = r_write_word;
    assign bus.ocd_reg_write_addr = r_reg_addr;
    assign bus.ocd_reg_write_data = r_reg_data;
    assign bus.start_address      = r_start_addr;
    assign bus.tx_valid           = w_tx_valid;
    assign bus.tx_byte            = r_resp[39:32];
endmodule
`default_nettype wire

// File: tb/tb_ocd_frame_parser.sv
`timescale 1ns/1ns
`default_nettype none
// ============================================================================
//  Module      : tb_ocd_frame_parser
//  Description : Self-checking bench for ocd_frame_parser. Frames are built
//                from command/address/data fields, the expected core actions
//                and response bytes come from a field-level model, and a
//                monitor collects what the parser actually did.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ocd_frame_parser;
    localparam int  MEM_ADDR_BITS  = 16;
    localparam int  REG_ADDR_BITS  = 5;
    localparam int  TIMEOUT_CYCLES = 40;
    localparam time PERIOD         = 10;

    typedef struct {
        int          kind;   // 1 write, 2 read, 3 reg write, 4 start
        logic [31:0] a;
        logic [31:0] d;
        time         t;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sync_reset = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    ev_t        obs_q[$];
    ev_t        exp_q[$];
    logic [7:0] tx_obs[$];
    logic [7:0] tx_exp[$];

    // model view of the held output registers
    logic [31:0] h_rw_addr, h_wword, h_reg_a, h_reg_d, h_start;

    // read-return and tx_ready controls (written only by the main process)
    int          rd_delay_cfg = 2;
    bit          rd_mute      = 1'b0;
    logic [31:0] rd_data_cfg  = 32'h0;
    int          stall_cycles = 0;
    int          stall_gen    = 0;

    ocd_frame_parser_if #(.MEM_ADDR_BITS(MEM_ADDR_BITS), .REG_ADDR_BITS(REG_ADDR_BITS)) bus ();

    ocd_frame_parser #(
        .MEM_ADDR_BITS (MEM_ADDR_BITS),
        .REG_ADDR_BITS (REG_ADDR_BITS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sync_reset(sync_reset),
        .bus       (bus)
    );

    always #(PERIOD/2) clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic ev_t mk_ev(input int k, input logic [31:0] a, input logic [31:0] d, input time t);
        ev_t e;
        e.kind = k; e.a = a; e.d = d; e.t = t;
        return e;
    endfunction

    // ---------------------------------------------------------------- monitor
    logic [7:0] tx_prev;
    bit         tx_pend  = 1'b0;
    int         stall_left = 0;
    int         stall_seen = 0;

    always @(negedge clk) begin
        if (bus.ocd_write_enable) obs_q.push_back(mk_ev(1, 32'(bus.ocd_rw_addr), bus.ocd_write_word, $time));
        if (bus.ocd_read_enable)  obs_q.push_back(mk_ev(2, 32'(bus.ocd_rw_addr), 32'h0, $time));
        if (bus.ocd_reg_we)       obs_q.push_back(mk_ev(3, 32'(bus.ocd_reg_write_addr), bus.ocd_reg_write_data, $time));
        if (bus.start)            obs_q.push_back(mk_ev(4, 32'h0, bus.start_address, $time));

        // a byte offered but not taken must still be offered, unchanged
        if (!reset_n || sync_reset) tx_pend = 1'b0;
        else if (tx_pend) check_eq("tx_hold", {55'h0, bus.tx_valid, bus.tx_byte}, {55'h0, 1'b1, tx_prev});

        if (stall_seen != stall_gen) begin
            stall_left = stall_cycles;
            stall_seen = stall_gen;
        end
        if (stall_left > 0) begin
            bus.tx_ready = 1'b0;
            if (bus.tx_valid) stall_left--;
        end else begin
            bus.tx_ready = ($urandom_range(3) != 0);
        end

        // outputs are stable until the next rising edge, so this is what it samples
        if (bus.tx_valid && bus.tx_ready && reset_n && !sync_reset) begin
            tx_obs.push_back(bus.tx_byte);
            tx_pend = 1'b0;
        end else begin
            tx_pend = bus.tx_valid;
            tx_prev = bus.tx_byte;
        end
    end

    // ------------------------------------------------------- core read return
    int          rd_cnt = -1;
    logic [31:0] rd_word;
    always @(negedge clk) begin
        bus.ocd_mem_enable_out = 1'b0;
        if (rd_cnt == 0) begin
            bus.ocd_mem_enable_out = 1'b1;
            bus.ocd_mem_word_out   = rd_word;
            rd_cnt = -1;
        end else if (rd_cnt > 0) begin
            rd_cnt--;
        end
        if (bus.ocd_read_enable && !rd_mute) begin
            rd_cnt  = rd_delay_cfg - 1;
            rd_word = rd_data_cfg;
        end
    end

    // ---------------------------------------------------------------- drivers
    task automatic send_byte(input logic [7:0] b, output time t_drv);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        t_drv = $time;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic check_held(input string tag);
        check_eq({tag, "_rw_addr"}, 64'(bus.ocd_rw_addr), 64'(h_rw_addr));
        check_eq({tag, "_wword"},   64'(bus.ocd_write_word), 64'(h_wword));
        check_eq({tag, "_reg_a"},   64'(bus.ocd_reg_write_addr), 64'(h_reg_a));
        check_eq({tag, "_reg_d"},   64'(bus.ocd_reg_write_data), 64'(h_reg_d));
        check_eq({tag, "_start_a"}, 64'(bus.start_address), 64'(h_start));
    endtask

    // Builds one frame, predicts its effects from the field values, sends it
    // and compares what the parser did against the prediction.
    task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [31:0] addr,
                             input logic [31:0] data, input bit bad);
        logic [7:0] fr[11];
        logic [7:0] cs;
        time        t_cs, t_x;
        int         ob0, tb0, budget;

        cs = cmd ^ addr[31:24] ^ addr[23:16] ^ addr[15:8] ^ addr[7:0]
                 ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0];
        fr[0] = 8'h5A;
        fr[1] = cmd;
        for (int i = 0; i < 4; i++) begin
            fr[2+i] = addr[31-8*i -: 8];
            fr[6+i] = data[31-8*i -: 8];
        end
        fr[10] = bad ? (cs ^ (8'h01 << $urandom_range(7))) : cs;

        exp_q.delete();
        tx_exp.delete();
        if (bad) begin
            tx_exp.push_back(8'hEE);
        end else begin
            case (cmd)
                8'h01: begin
                    exp_q.push_back(mk_ev(1, 32'(addr[MEM_ADDR_BITS+1:2]), data, 0));
                    h_rw_addr = 32'(addr[MEM_ADDR_BITS+1:2]);
                    h_wword   = data;
                    tx_exp.push_back(8'hA5);
                end
                8'h02: begin
                    exp_q.push_back(mk_ev(2, 32'(addr[MEM_ADDR_BITS+1:2]), 32'h0, 0));
                    h_rw_addr = 32'(addr[MEM_ADDR_BITS+1:2]);
                    if (rd_mute) begin
                        tx_exp.push_back(8'hEC);
                    end else begin
                        tx_exp.push_back(8'hA5);
                        for (int i = 0; i < 4; i++) tx_exp.push_back(rd_data_cfg[31-8*i -: 8]);
                    end
                end
                8'h03: begin
                    exp_q.push_back(mk_ev(3, 32'(addr[REG_ADDR_BITS-1:0]), data, 0));
                    h_reg_a = 32'(addr[REG_ADDR_BITS-1:0]);
                    h_reg_d = data;
                    tx_exp.push_back(8'hA5);
                end
                8'h04: begin
                    exp_q.push_back(mk_ev(4, 32'h0, data, 0));
                    h_start = data;
                    tx_exp.push_back(8'hA5);
                end
                default: tx_exp.push_back(8'hEF);
            endcase
        end

        ob0 = obs_q.size();
        tb0 = tx_obs.size();
        t_cs = 0;
        for (int i = 0; i < 11; i++) begin
            repeat ($urandom_range(3)) @(negedge clk);
            send_byte(fr[i], t_x);
            if (i == 10) t_cs = t_x;
        end

        budget = 100 + 3 * TIMEOUT_CYCLES;
        while ((tx_obs.size() - tb0) < tx_exp.size() && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (4) @(negedge clk);

        check_eq({tag, "_tx_len"}, 64'(tx_obs.size() - tb0), 64'(tx_exp.size()));
        foreach (tx_exp[i])
            if (tb0 + i < tx_obs.size())
                check_eq($sformatf("%s_tx%0d", tag, i), 64'(tx_obs[tb0+i]), 64'(tx_exp[i]));
        check_eq({tag, "_n_actions"}, 64'(obs_q.size() - ob0), 64'(exp_q.size()));
        foreach (exp_q[i])
            if (ob0 + i < obs_q.size()) begin
                check_eq({tag, "_act_kind"}, 64'(obs_q[ob0+i].kind), 64'(exp_q[i].kind));
                check_eq({tag, "_act_addr"}, 64'(obs_q[ob0+i].a), 64'(exp_q[i].a));
                check_eq({tag, "_act_data"}, 64'(obs_q[ob0+i].d), 64'(exp_q[i].d));
                // strobe is seen in the cycle right after the checksum edge
                check_eq({tag, "_act_time"}, 64'(obs_q[ob0+i].t), 64'(t_cs + PERIOD));
            end
        check_held(tag);
    endtask

    // ------------------------------------------------------------------- main
    initial begin
        time t_x;
        int  ob0, tb0;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        h_rw_addr = 0; h_wword = 0; h_reg_a = 0; h_reg_d = 0; h_start = 0;

        repeat (3) @(negedge clk);
        check_eq("reset_strobes",
                 64'({bus.ocd_write_enable, bus.ocd_read_enable, bus.ocd_reg_we, bus.start, bus.tx_valid}), 64'h0);
        check_held("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // reference frames; checksum byte always derived from the XOR rule
        run_frame("wr", 8'h01, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        rd_delay_cfg = 3; rd_data_cfg = 32'h1234_5678; rd_mute = 1'b0;
        stall_cycles = 5; stall_gen++;
        run_frame("rd", 8'h02, 32'h0000_0010, 32'h0000_0000, 1'b0);
        run_frame("regbad", 8'h03, 32'h0000_0007, 32'h0000_0055, 1'b1);
        run_frame("reg", 8'h03, 32'h0000_0007, 32'h0000_0055, 1'b0);
        run_frame("start", 8'h04, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_frame("badcmd", 8'h07, 32'h1111_2222, 32'h3333_4444, 1'b0);
        run_frame("sync_in_data", 8'h01, 32'h0000_5A5A, 32'h5A5A_5A5A, 1'b0);
        rd_mute = 1'b1;
        run_frame("rd_to", 8'h02, 32'h0000_0100, 32'h0, 1'b0);
        rd_mute = 1'b0;

        // asynchronous reset in the middle of the address bytes
        send_byte(8'h5A, t_x);
        send_byte(8'h01, t_x);
        send_byte(8'hAB, t_x);
        send_byte(8'hCD, t_x);
        #2 reset_n = 1'b0;
        #1;
        h_rw_addr = 0; h_wword = 0; h_reg_a = 0; h_reg_d = 0; h_start = 0;
        check_eq("arst_strobes",
                 64'({bus.ocd_write_enable, bus.ocd_read_enable, bus.ocd_reg_we, bus.start, bus.tx_valid}), 64'h0);
        check_held("arst");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_frame("after_rst", 8'h01, 32'h0000_0020, 32'hCAFE_F00D, 1'b0);

        // partial frame abandoned by the inter-byte timeout
        ob0 = obs_q.size();
        tb0 = tx_obs.size();
        send_byte(8'h00, t_x);
        send_byte(8'hFF, t_x);
        send_byte(8'h5A, t_x);
        send_byte(8'h01, t_x);
        repeat (TIMEOUT_CYCLES + 5) @(negedge clk);
        check_eq("to_no_tx", 64'(tx_obs.size() - tb0), 64'h0);
        check_eq("to_no_action", 64'(obs_q.size() - ob0), 64'h0);
        run_frame("after_to", 8'h04, 32'h0, 32'h0000_4000, 1'b0);

        // randomized frames with noise bytes in between
        for (int n = 0; n < 30; n++) begin
            logic [7:0] cmd, nb;
            int sel;
            sel = $urandom_range(9);
            if (sel < 2)      cmd = 8'h01;
            else if (sel < 4) cmd = 8'h02;
            else if (sel < 6) cmd = 8'h03;
            else if (sel < 8) cmd = 8'h04;
            else              cmd = 8'($urandom_range(255));
            rd_mute      = ($urandom_range(7) == 0);
            rd_delay_cfg = $urandom_range(1, 6);
            rd_data_cfg  = $urandom;
            if ($urandom_range(3) == 0) begin
                stall_cycles = $urandom_range(1, 6);
                stall_gen++;
            end
            repeat ($urandom_range(2)) begin
                nb = 8'($urandom_range(255));
                if (nb == 8'h5A) nb = 8'h00;
                send_byte(nb, t_x);
            end
            run_frame($sformatf("rnd%0d", n), cmd, $urandom, $urandom, ($urandom_range(5) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #(PERIOD * 90000);
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
